hazard_forward_unit: RTL and testbench

Generates the 2-bit EX-stage operand-source selects (ForwardA/ForwardB) consumed by the ALU source muxes. Tracks destination-register information for instructions in EX and MEM, detects load-use hazards, and inserts a one-cycle bubble. It sits beside the ID/EX pipeline register. Its select outputs are registered so they are valid for the whole cycle an instruction occupies EX.

---
 rtl/hazard_pkg.sv | 26 ++
 rtl/hazard_forward_unit_if.sv | 30 +++
 rtl/hazard_forward_unit_fwd_sel_compare.sv | 22 ++
 rtl/hazard_forward_unit.sv | 125 ++++++++++++
 tb/tb_hazard_forward_unit.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the EX-stage forwarding / load-use hazard unit.
// Slot register indices are held at a fixed maximum width so one struct serves any REG_ADDR_W <= 8.
package hazard_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam int RD_W_MAX = 8;

    typedef logic [RD_W_MAX-1:0] reg_idx_t;

    localparam reg_idx_t REG_ZERO = '0;

    typedef struct packed {
        logic     valid;
        reg_idx_t rd;
        logic     reg_write;
    } slot_t;

    // A slot is a forwarding candidate only if it really produces a non-x0 result.
    function automatic logic slot_writes(input slot_t s);
        return s.valid && s.reg_write && (s.rd != REG_ZERO);
    endfunction

endpackage

// File: rtl/hazard_forward_unit_if.sv
// ID-stage instruction info and pipeline controls in; forward selects, stall/bubble and stall counter out.
// The control side drives through master, the hazard unit attaches through slave.
interface hazard_forward_unit_if #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
);
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic [REG_ADDR_W-1:0] id_rd;
    logic                  id_reg_write;
    logic                  id_mem_read;
    logic                  pipe_stall;
    logic                  flush;
    logic [1:0]            ForwardA;
    logic [1:0]            ForwardB;
    logic                  id_stall;
    logic                  ex_bubble;
    logic [CNT_W-1:0]      stall_count;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rd, id_reg_write, id_mem_read, pipe_stall, flush,
        input  ForwardA, ForwardB, id_stall, ex_bubble, stall_count
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rd, id_reg_write, id_mem_read, pipe_stall, flush,
        output ForwardA, ForwardB, id_stall, ex_bubble, stall_count
    );
endinterface

// File: rtl/hazard_forward_unit_fwd_sel_compare.sv
// Combinational next-select for one source operand: EX-slot producer beats MEM-slot producer.
// A load in EX never forwards; that case is resolved by the load-use stall instead.
module fwd_sel_compare
    import hazard_pkg::*;
(
    input  slot_t      ex_slot_i,
    input  logic       ex_is_load_i,
    input  slot_t      mem_slot_i,
    input  reg_idx_t   rs_i,
    output logic [1:0] sel_o
);

    always_comb begin
        sel_o = FWD_RF;
        if (slot_writes(ex_slot_i) && !ex_is_load_i && (ex_slot_i.rd == rs_i)) begin
            sel_o = FWD_MEM;
        end else if (slot_writes(mem_slot_i) && (mem_slot_i.rd == rs_i)) begin
            sel_o = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_forward_unit.sv
// Tracks EX/MEM destination slots, registers ForwardA/B for the EX cycle, and raises a one-bubble load-use stall.
// Optional load-use stall counter is built only when HAZARD_STALL_CNT_EN is defined; otherwise stall_count is 0.
module hazard_forward_unit
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    hazard_forward_unit_if.slave   bus
);

    slot_t      ex_q, ex_d;
    slot_t      mem_q, mem_d;
    logic       ex_load_q, ex_load_d;
    logic [1:0] fwd_a_q, fwd_a_d;
    logic [1:0] fwd_b_q, fwd_b_d;

    reg_idx_t   rs1_x, rs2_x, rd_x;
    slot_t      id_slot;
    logic [1:0] sel_a, sel_b;
    logic       load_use;
    logic       ex_bubble;

    always_comb begin
        rs1_x = '0;
        rs2_x = '0;
        rd_x  = '0;
        rs1_x[REG_ADDR_W-1:0] = bus.id_rs1;
        rs2_x[REG_ADDR_W-1:0] = bus.id_rs2;
        rd_x[REG_ADDR_W-1:0]  = bus.id_rd;
    end

    assign id_slot = '{valid: bus.id_valid, rd: rd_x, reg_write: bus.id_reg_write};

    fwd_sel_compare u_cmp_rs1 (
        .ex_slot_i    (ex_q),
        .ex_is_load_i (ex_load_q),
        .mem_slot_i   (mem_q),
        .rs_i         (rs1_x),
        .sel_o        (sel_a)
    );

    fwd_sel_compare u_cmp_rs2 (
        .ex_slot_i    (ex_q),
        .ex_is_load_i (ex_load_q),
        .mem_slot_i   (mem_q),
        .rs_i         (rs2_x),
        .sel_o        (sel_b)
    );

    assign load_use = slot_writes(ex_q) && ex_load_q && bus.id_valid
                    && ((ex_q.rd == rs1_x) || (ex_q.rd == rs2_x));

    // A global freeze suppresses both the stall and the bubble; flush pre-empts the stall.
    assign bus.id_stall  = load_use && !bus.flush && !bus.pipe_stall;
    assign ex_bubble     = (load_use || bus.flush) && !bus.pipe_stall;
    assign bus.ex_bubble = ex_bubble;

    always_comb begin
        ex_d      = ex_q;
        mem_d     = mem_q;
        ex_load_d = ex_load_q;
        fwd_a_d   = fwd_a_q;
        fwd_b_d   = fwd_b_q;
        if (!bus.pipe_stall) begin
            mem_d = ex_q;
            if (ex_bubble) begin
                ex_d      = '0;
                ex_load_d = 1'b0;
                fwd_a_d   = FWD_RF;
                fwd_b_d   = FWD_RF;
            end else begin
                ex_d      = id_slot;
                ex_load_d = bus.id_valid && bus.id_mem_read;
                fwd_a_d   = sel_a;
                fwd_b_d   = sel_b;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q      <= '0;
            mem_q     <= '0;
            ex_load_q <= 1'b0;
            fwd_a_q   <= FWD_RF;
            fwd_b_q   <= FWD_RF;
        end else begin
            ex_q      <= ex_d;
            mem_q     <= mem_d;
            ex_load_q <= ex_load_d;
            fwd_a_q   <= fwd_a_d;
            fwd_b_q   <= fwd_b_d;
        end
    end

    assign bus.ForwardA = fwd_a_q;
    assign bus.ForwardB = fwd_b_q;

`ifdef HAZARD_STALL_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (bus.id_stall && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.stall_count = cnt_q;
`else
    assign bus.stall_count = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed-vector bench for hazard_forward_unit: forwarding distances, priority, load-use, x0, freeze, flush, reset.
// Expected selects and stall counts are hand-computed from the pipeline timing.
module tb_hazard_forward_unit;

    localparam int RW = 5;
    localparam int CW = 32;
`ifdef HAZARD_STALL_CNT_EN
    localparam int CNT_ON = 1;
`else
    localparam int CNT_ON = 0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    hazard_forward_unit_if #(.REG_ADDR_W(RW), .CNT_W(CW)) bus ();

    hazard_forward_unit #(.REG_ADDR_W(RW), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [RW-1:0] rs1, input logic [RW-1:0] rs2,
                          input logic [RW-1:0] rd, input logic rw, input logic mr);
        bus.id_valid     = v;
        bus.id_rs1       = rs1;
        bus.id_rs2       = rs2;
        bus.id_rd        = rd;
        bus.id_reg_write = rw;
        bus.id_mem_read  = mr;
        #1;
    endtask

    task automatic chk_fwd(input string tag, input logic [1:0] a, input logic [1:0] b);
        chk({tag, ".fwdA"}, 32'(bus.ForwardA), 32'(a));
        chk({tag, ".fwdB"}, 32'(bus.ForwardB), 32'(b));
    endtask

    task automatic chk_hz(input string tag, input logic st, input logic bb);
        chk({tag, ".id_stall"},  32'(bus.id_stall),  32'(st));
        chk({tag, ".ex_bubble"}, 32'(bus.ex_bubble), 32'(bb));
    endtask

    initial begin
        rst = 1'b1;
        bus.pipe_stall = 1'b0;
        bus.flush      = 1'b0;
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        tick();
        tick();
        chk_fwd("reset", 2'b00, 2'b00);
        chk_hz("reset", 1'b0, 1'b0);
        chk("reset.cnt", bus.stall_count, 32'd0);
        rst = 1'b0;

        // Back-to-back ALU dependency
        set_id(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd5, 5'd6, 5'd8, 1'b1, 1'b0);
        chk_hz("b2b", 1'b0, 1'b0);
        tick();
        chk_fwd("b2b", 2'b10, 2'b00);

        // Distance-2 dependency
        set_id(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd3, 5'd4, 5'd9, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd10, 5'd7, 5'd11, 1'b1, 1'b0);
        tick();
        chk_fwd("dist2", 2'b00, 2'b01);

        // Two producers of x7: youngest wins
        set_id(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd7, 5'd7, 5'd12, 1'b1, 1'b0);
        tick();
        chk_fwd("prio", 2'b10, 2'b10);

        // Load-use: one bubble, then WB forward
        set_id(1'b1, 5'd1, 5'd0, 5'd3, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd3, 5'd4, 5'd11, 1'b1, 1'b0);
        chk_hz("lu.n", 1'b1, 1'b1);
        tick();
        chk_hz("lu.n1", 1'b0, 1'b0);
        chk_fwd("lu.bubble", 2'b00, 2'b00);
        tick();
        chk_fwd("lu.n2", 2'b01, 2'b00);
        chk("lu.cnt", bus.stall_count, 32'(CNT_ON));

        // x0 destination never forwards or stalls
        set_id(1'b1, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd0, 5'd0, 5'd13, 1'b1, 1'b0);
        chk_hz("x0.alu", 1'b0, 1'b0);
        tick();
        chk_fwd("x0.alu", 2'b00, 2'b00);
        set_id(1'b1, 5'd1, 5'd0, 5'd0, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd0, 5'd0, 5'd13, 1'b1, 1'b0);
        chk_hz("x0.lw", 1'b0, 1'b0);
        tick();
        chk_fwd("x0.lw", 2'b00, 2'b00);

        // Freeze during a pending load-use
        set_id(1'b1, 5'd1, 5'd2, 5'd12, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd12, 5'd0, 5'd13, 1'b1, 1'b1);
        tick();
        chk_fwd("frz.pre", 2'b10, 2'b00);
        set_id(1'b1, 5'd0, 5'd13, 5'd14, 1'b1, 1'b0);
        chk_hz("frz.pend", 1'b1, 1'b1);
        bus.pipe_stall = 1'b1;
        #1;
        chk_hz("frz.on", 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_fwd($sformatf("frz.c%0d", i), 2'b10, 2'b00);
            chk_hz($sformatf("frz.c%0d", i), 1'b0, 1'b0);
        end
        bus.pipe_stall = 1'b0;
        #1;
        chk_hz("frz.rel", 1'b1, 1'b1);
        tick();
        chk_hz("frz.after", 1'b0, 1'b0);
        chk_fwd("frz.bubble", 2'b00, 2'b00);
        tick();
        chk_fwd("frz.use", 2'b00, 2'b01);
        chk("frz.cnt", bus.stall_count, 32'(2 * CNT_ON));

        // Flush pre-empts a pending load-use
        set_id(1'b1, 5'd1, 5'd0, 5'd15, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd15, 5'd0, 5'd16, 1'b1, 1'b0);
        bus.flush = 1'b1;
        #1;
        chk_hz("flush", 1'b0, 1'b1);
        tick();
        bus.flush = 1'b0;
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        chk_fwd("flush.ex", 2'b00, 2'b00);
        chk_hz("flush.ex", 1'b0, 1'b0);
        chk("flush.cnt", bus.stall_count, 32'(2 * CNT_ON));

        // Reset in the middle of a stall
        set_id(1'b1, 5'd1, 5'd2, 5'd18, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd18, 5'd0, 5'd17, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd0, 5'd17, 5'd19, 1'b1, 1'b0);
        chk_hz("rst.pend", 1'b1, 1'b1);
        chk_fwd("rst.pend", 2'b10, 2'b00);
        rst = 1'b1;
        tick();
        chk_fwd("rst.mid", 2'b00, 2'b00);
        chk_hz("rst.mid", 1'b0, 1'b0);
        chk("rst.cnt", bus.stall_count, 32'd0);
        rst = 1'b0;
        tick();
        chk_hz("rst.after", 1'b0, 1'b0);
        chk_fwd("rst.after", 2'b00, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
